// File: rtl/ahbmtx_l1_input_stage.sv
// L1 bus matrix slave-port input stage: holds an address phase the output stage cannot take yet.
// Optional HAUSERS sideband enabled by defining AHBMTX_L1_IN_STG_USER_EN.
module ahbmtx_l1_input_stage #(
  parameter int MW = 4
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          HSELS,
  input  logic [31:0]   HADDRS,
  input  logic [1:0]    HTRANSS,
  input  logic          HWRITES,
  input  logic [2:0]    HSIZES,
  input  logic [2:0]    HBURSTS,
  input  logic [3:0]    HPROTS,
  input  logic [MW-1:0] HMASTERS,
  input  logic          HMASTLOCKS,
  input  logic          HREADYS,
`ifdef AHBMTX_L1_IN_STG_USER_EN
  input  logic [31:0]   HAUSERS,
`endif
  output logic          HREADYOUTS,
  output logic [1:0]    HRESPS,
  output logic          sel_op,
  output logic [31:0]   addr_op,
  output logic [1:0]    trans_op,
  output logic          write_op,
  output logic [2:0]    size_op,
  output logic [2:0]    burst_op,
  output logic [3:0]    prot_op,
  output logic [MW-1:0] master_op,
  output logic          mastlock_op,
  output logic [31:0]   auser_op,
  output logic          held_tran_op,
  output logic          ready_op,
  input  logic          active_op,
  input  logic          readyout_op,
  input  logic [1:0]    resp_op
);

  localparam logic [1:0] TRN_IDLE    = 2'b00;
  localparam logic [1:0] TRN_NONSEQ  = 2'b10;
  localparam logic [2:0] BURST_INCR  = 3'b001;

  logic          reg_valid;
  logic          data_valid;
  logic [31:0]   addr_p1;
  logic [1:0]    trans_p1;
  logic          write_p1;
  logic [2:0]    size_p1;
  logic [2:0]    burst_p1;
  logic [3:0]    prot_p1;
  logic [MW-1:0] master_p1;
  logic          mastlock_p1;
  logic [31:0]   auser_p1;
  logic [31:0]   auser_live;

  logic accept;
  logic load;
  logic issue_held;
  logic issue_pass;
  logic is_seq;

`ifdef AHBMTX_L1_IN_STG_USER_EN
  assign auser_live = HAUSERS;
`else
  assign auser_live = 32'h0;
`endif

  assign accept     = HSELS & HTRANSS[1] & HREADYS;
  assign load       = accept & ~active_op & ~reg_valid;
  assign issue_held = reg_valid & active_op;
  assign issue_pass = accept & active_op & ~reg_valid;
  assign is_seq     = HTRANSS[0];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      reg_valid  <= 1'b0;
      data_valid <= 1'b0;
    end else begin
      if (issue_held)
        reg_valid <= 1'b0;
      else if (load)
        reg_valid <= 1'b1;

      if (issue_held || issue_pass)
        data_valid <= 1'b1;
      else if (readyout_op)
        data_valid <= 1'b0;
    end
  end

  // Holding register: a SEQ beat loses its burst context once stalled, so it re-enters as NONSEQ/INCR.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_p1     <= '0;
      trans_p1    <= '0;
      write_p1    <= 1'b0;
      size_p1     <= '0;
      burst_p1    <= '0;
      prot_p1     <= '0;
      master_p1   <= '0;
      mastlock_p1 <= 1'b0;
      auser_p1    <= '0;
    end else if (load) begin
      addr_p1     <= HADDRS;
      trans_p1    <= is_seq ? TRN_NONSEQ : HTRANSS;
      write_p1    <= HWRITES;
      size_p1     <= HSIZES;
      burst_p1    <= is_seq ? BURST_INCR : HBURSTS;
      prot_p1     <= HPROTS;
      master_p1   <= HMASTERS;
      mastlock_p1 <= HMASTLOCKS;
      auser_p1    <= auser_live;
    end
  end

  // Decoder-side mux: held transfer takes precedence over the live address phase.
  always_comb begin
    sel_op      = reg_valid | HSELS;
    addr_op     = reg_valid ? addr_p1     : HADDRS;
    trans_op    = reg_valid ? trans_p1    : (HSELS ? HTRANSS : TRN_IDLE);
    write_op    = reg_valid ? write_p1    : HWRITES;
    size_op     = reg_valid ? size_p1     : HSIZES;
    burst_op    = reg_valid ? burst_p1    : HBURSTS;
    prot_op     = reg_valid ? prot_p1     : HPROTS;
    master_op   = reg_valid ? master_p1   : HMASTERS;
    mastlock_op = reg_valid ? mastlock_p1 : HMASTLOCKS;
    auser_op    = reg_valid ? auser_p1    : auser_live;
    ready_op    = reg_valid ? 1'b1        : HREADYS;
  end

  assign held_tran_op = reg_valid;
  assign HREADYOUTS   = reg_valid ? 1'b0 : (data_valid ? readyout_op : 1'b1);
  assign HRESPS       = (data_valid & ~reg_valid) ? resp_op : 2'b00;

endmodule

// File: tb/tb_ahbmtx_l1_input_stage.sv
// Directed table-driven bench for ahbmtx_l1_input_stage; each table row is one clock cycle.
module tb_ahbmtx_l1_input_stage;

  localparam int MW = 4;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic          HSELS;
  logic [31:0]   HADDRS;
  logic [1:0]    HTRANSS;
  logic          HWRITES;
  logic [2:0]    HSIZES;
  logic [2:0]    HBURSTS;
  logic [3:0]    HPROTS;
  logic [MW-1:0] HMASTERS;
  logic          HMASTLOCKS;
  logic          HREADYS;
  logic [31:0]   HAUSERS;
  logic          HREADYOUTS;
  logic [1:0]    HRESPS;
  logic          sel_op;
  logic [31:0]   addr_op;
  logic [1:0]    trans_op;
  logic          write_op;
  logic [2:0]    size_op;
  logic [2:0]    burst_op;
  logic [3:0]    prot_op;
  logic [MW-1:0] master_op;
  logic          mastlock_op;
  logic [31:0]   auser_op;
  logic          held_tran_op;
  logic          ready_op;
  logic          active_op;
  logic          readyout_op;
  logic [1:0]    resp_op;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 HCLK = ~HCLK;

  ahbmtx_l1_input_stage #(.MW(MW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSELS(HSELS), .HADDRS(HADDRS), .HTRANSS(HTRANSS),
    .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS), .HPROTS(HPROTS),
    .HMASTERS(HMASTERS), .HMASTLOCKS(HMASTLOCKS), .HREADYS(HREADYS),
`ifdef AHBMTX_L1_IN_STG_USER_EN
    .HAUSERS(HAUSERS),
`endif
    .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS), .sel_op(sel_op), .addr_op(addr_op),
    .trans_op(trans_op), .write_op(write_op), .size_op(size_op), .burst_op(burst_op),
    .prot_op(prot_op), .master_op(master_op), .mastlock_op(mastlock_op), .auser_op(auser_op),
    .held_tran_op(held_tran_op), .ready_op(ready_op), .active_op(active_op),
    .readyout_op(readyout_op), .resp_op(resp_op)
  );

  typedef struct {
    logic        sel;
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  burst;
    logic        hrdy;
    logic        act;
    logic        rdyout;
    logic [1:0]  resp;
    logic        e_hro;
    logic [1:0]  e_resp;
    logic        e_held;
    logic        e_sel;
    logic [1:0]  e_trans;
    logic [31:0] e_addr;
    logic [2:0]  e_burst;
    logic        e_wr;
  } vec_t;

  vec_t vec [19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic sel, input logic [31:0] addr, input logic [1:0] trans,
                       input logic wr, input logic [2:0] burst, input logic hrdy,
                       input logic act, input logic rdyout, input logic [1:0] resp);
    HSELS = sel; HADDRS = addr; HTRANSS = trans; HWRITES = wr; HBURSTS = burst;
    HREADYS = hrdy; active_op = act; readyout_op = rdyout; resp_op = resp;
  endtask

  initial begin
    HSIZES = 3'b010; HPROTS = 4'b0011; HMASTERS = 4'h5; HMASTLOCKS = 1'b0; HAUSERS = 32'hA5A5_0001;

    //             sel   addr          trans  wr    burst   hrdy  act   rdyo  resp     hro   resp   held  sel   trans  addr          burst   wr
    vec[0]  = '{1'b0, 32'h0,        2'b00, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 2'b00,  1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 32'h0,        3'b000, 1'b0};
    vec[1]  = '{1'b1, 32'h4003_0000, 2'b10, 1'b0, 3'b000, 1'b1, 1'b1, 1'b1, 2'b00,  1'b1, 2'b00, 1'b0, 1'b1, 2'b10, 32'h4003_0000, 3'b000, 1'b0};
    vec[2]  = '{1'b0, 32'h0,        2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 2'b00,  1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 32'h0,        3'b000, 1'b0};
    vec[3]  = '{1'b0, 32'h0,        2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 2'b00,  1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 32'h0,        3'b000, 1'b0};
    vec[4]  = '{1'b1, 32'h5000_0010, 2'b10, 1'b1, 3'b000, 1'b1, 1'b0, 1'b1, 2'b00,  1'b1, 2'b00, 1'b0, 1'b1, 2'b10, 32'h5000_0010, 3'b000, 1'b1};
    vec[5]  = '{1'b0, 32'hDEAD_0000, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 2'b00,  1'b0, 2'b00, 1'b1, 1'b1, 2'b10, 32'h5000_0010, 3'b000, 1'b1};
    vec[6]  = '{1'b0, 32'hDEAD_0000, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 2'b00,  1'b0, 2'b00, 1'b1, 1'b1, 2'b10, 32'h5000_0010, 3'b000, 1'b1};
    vec[7]  = '{1'b0, 32'hDEAD_0000, 2'b00, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 2'b00,  1'b0, 2'b00, 1'b1, 1'b1, 2'b10, 32'h5000_0010, 3'b000, 1'b1};
    vec[8]  = '{1'b0, 32'h0,        2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 2'b00,  1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 32'h0,        3'b000, 1'b0};
    vec[9]  = '{1'b1, 32'h6000_0004, 2'b11, 1'b0, 3'b011, 1'b1, 1'b0, 1'b1, 2'b00,  1'b1, 2'b00, 1'b0, 1'b1, 2'b11, 32'h6000_0004, 3'b011, 1'b0};
    vec[10] = '{1'b0, 32'h0,        2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 2'b00,  1'b0, 2'b00, 1'b1, 1'b1, 2'b10, 32'h6000_0004, 3'b001, 1'b0};
    vec[11] = '{1'b0, 32'h0,        2'b00, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 2'b01,  1'b0, 2'b00, 1'b1, 1'b1, 2'b10, 32'h6000_0004, 3'b001, 1'b0};
    vec[12] = '{1'b0, 32'h0,        2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 2'b01,  1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 32'h0,        3'b000, 1'b0};
    vec[13] = '{1'b0, 32'h0,        2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 2'b01,  1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 32'h0,        3'b000, 1'b0};
    vec[14] = '{1'b1, 32'h7000_0000, 2'b00, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 2'b01,  1'b1, 2'b00, 1'b0, 1'b1, 2'b00, 32'h7000_0000, 3'b000, 1'b0};
    vec[15] = '{1'b0, 32'h0,        2'b00, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 2'b00,  1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 32'h0,        3'b000, 1'b0};
    vec[16] = '{1'b1, 32'h7000_0100, 2'b10, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 2'b00,  1'b1, 2'b00, 1'b0, 1'b1, 2'b10, 32'h7000_0100, 3'b000, 1'b0};
    vec[17] = '{1'b1, 32'h7000_0200, 2'b01, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 2'b00,  1'b1, 2'b00, 1'b0, 1'b1, 2'b01, 32'h7000_0200, 3'b000, 1'b0};
    vec[18] = '{1'b0, 32'h0,        2'b00, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 2'b00,  1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 32'h0,        3'b000, 1'b0};

    // Reset with a would-be accept on the inputs: nothing may load.
    HRESETn = 1'b0;
    drive(1'b1, 32'h1234_5678, 2'b10, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 2'b01);
    @(posedge HCLK); #3;
    check("rst_hreadyout", {31'h0, HREADYOUTS}, 32'h1);
    check("rst_hresp", {30'h0, HRESPS}, 32'h0);
    check("rst_held", {31'h0, held_tran_op}, 32'h0);
    drive(1'b0, 32'h0, 2'b00, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 2'b00);
    #1 HRESETn = 1'b1;
    #1 check("rst_trans_idle", {30'h0, trans_op}, 32'h0);

    for (int i = 0; i < 19; i++) begin
      @(posedge HCLK); #1;
      drive(vec[i].sel, vec[i].addr, vec[i].trans, vec[i].wr, vec[i].burst,
            vec[i].hrdy, vec[i].act, vec[i].rdyout, vec[i].resp);
      @(negedge HCLK);
      check($sformatf("v%0d_hreadyout", i), {31'h0, HREADYOUTS}, {31'h0, vec[i].e_hro});
      check($sformatf("v%0d_hresp", i), {30'h0, HRESPS}, {30'h0, vec[i].e_resp});
      check($sformatf("v%0d_held", i), {31'h0, held_tran_op}, {31'h0, vec[i].e_held});
      check($sformatf("v%0d_sel", i), {31'h0, sel_op}, {31'h0, vec[i].e_sel});
      check($sformatf("v%0d_trans", i), {30'h0, trans_op}, {30'h0, vec[i].e_trans});
      check($sformatf("v%0d_addr", i), addr_op, vec[i].e_addr);
      check($sformatf("v%0d_burst", i), {29'h0, burst_op}, {29'h0, vec[i].e_burst});
      check($sformatf("v%0d_write", i), {31'h0, write_op}, {31'h0, vec[i].e_wr});
      check($sformatf("v%0d_ready_op", i), {31'h0, ready_op}, {31'h0, (vec[i].e_held | vec[i].hrdy)});
    end

    // Capture of side fields, then reset while held: transfer discarded.
    @(posedge HCLK); #1;
    HSIZES = 3'b001; HPROTS = 4'b1010; HMASTERS = 4'h9; HMASTLOCKS = 1'b1;
    drive(1'b1, 32'h8000_0040, 2'b10, 1'b1, 3'b000, 1'b1, 1'b0, 1'b1, 2'b00);
    @(posedge HCLK); #1;
    HSIZES = 3'b000; HPROTS = 4'b0000; HMASTERS = 4'h0; HMASTLOCKS = 1'b0;
    drive(1'b0, 32'h0, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 2'b00);
    @(negedge HCLK);
    check("hold_held", {31'h0, held_tran_op}, 32'h1);
    check("hold_size", {29'h0, size_op}, 32'h1);
    check("hold_prot", {28'h0, prot_op}, 32'hA);
    check("hold_master", {28'h0, master_op}, 32'h9);
    check("hold_mastlock", {31'h0, mastlock_op}, 32'h1);
`ifdef AHBMTX_L1_IN_STG_USER_EN
    check("hold_auser", auser_op, 32'hA5A5_0001);
`else
    check("auser_tied", auser_op, 32'h0);
`endif
    #1 HRESETn = 1'b0;
    #1;
    check("midrst_held", {31'h0, held_tran_op}, 32'h0);
    check("midrst_hreadyout", {31'h0, HREADYOUTS}, 32'h1);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    drive(1'b0, 32'h0, 2'b00, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 2'b10);
    @(posedge HCLK); #1;
    check("postrst_no_issue_hro", {31'h0, HREADYOUTS}, 32'h1);
    check("postrst_no_issue_resp", {30'h0, HRESPS}, 32'h0);
    check("postrst_held", {31'h0, held_tran_op}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
